afu_rsp_delay: RTL

AFU_RSP_DELAY -- requirements
Module: afu_rsp_delay

---
 rtl/afu_rsp_delay.sv | 113 +++++++++++
 1 files changed

// File: rtl/afu_rsp_delay.sv
// Read-response delay line: buffers memory-controller read beats and releases each
// one to the CXL IP once it has aged a programmable number of cycles.
module afu_rsp_delay #(
  parameter int FIFO_DEPTH = 64,
  parameter int TS_W       = 17
) (
  input  logic         afu_clk,
  input  logic         afu_rstn,
  input  logic         mc_rvalid,
  input  logic [11:0]  mc_rid,
  input  logic [511:0] mc_rdata,
  input  logic         mc_ruser,
  output logic         mc_rready,
  output logic         ip_rvalid,
  output logic [11:0]  ip_rid,
  output logic [511:0] ip_rdata,
  output logic         ip_ruser,
  output logic         ip_rlast,
  input  logic [63:0]  afu_data,
  output logic [6:0]   occupancy,
  output logic [6:0]   max_occupancy
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [46:0] CFG_MAGIC = 47'h51AE_D31A_C0DE;

  logic [TS_W-1:0]  now;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [6:0]       count;
  logic [6:0]       count_next;
  logic [6:0]       max_occ;
  logic [15:0]      delay_reg;
  logic [15:0]      delay_eff;
  logic [TS_W-1:0]  elapsed;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic             cfg_wr;

  logic [11:0]      mem_rid   [FIFO_DEPTH];
  logic [511:0]     mem_data  [FIFO_DEPTH];
  logic             mem_user  [FIFO_DEPTH];
  logic [TS_W-1:0]  mem_stamp [FIFO_DEPTH];

  assign empty     = (count == 7'd0);
  assign full      = (count == 7'(FIFO_DEPTH));
  assign mc_rready = !full;
  assign push      = mc_rvalid && mc_rready;
  assign cfg_wr    = (afu_data[63:17] == CFG_MAGIC);

  // A zero delay still costs one cycle through the buffer.
  assign delay_eff = (delay_reg == 16'd0) ? 16'd1 : delay_reg;
  assign elapsed   = now - mem_stamp[rd_ptr];
  assign pop       = !empty && (elapsed >= TS_W'(delay_eff));

  assign ip_rvalid     = pop;
  assign ip_rlast      = pop;
  assign ip_rid        = mem_rid[rd_ptr];
  assign ip_rdata      = mem_data[rd_ptr];
  assign ip_ruser      = mem_user[rd_ptr];
  assign occupancy     = count;
  assign max_occupancy = max_occ;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 7'd1;
    end else if (!push && pop) begin
      count_next = count - 7'd1;
    end
  end

  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      now       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_occ   <= '0;
      delay_reg <= '0;
    end else begin
      now   <= now + TS_W'(1);
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (cfg_wr) begin
        delay_reg <= afu_data[15:0];
      end
      if (cfg_wr && afu_data[16]) begin
        max_occ <= count;
      end else if (count_next > max_occ) begin
        max_occ <= count_next;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge afu_clk) begin
    if (push) begin
      mem_rid[wr_ptr]   <= mc_rid;
      mem_data[wr_ptr]  <= mc_rdata;
      mem_user[wr_ptr]  <= mc_ruser;
      mem_stamp[wr_ptr] <= now;
    end
  end

endmodule
